fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Program-counter and fetch stage of the LEGv8 datapath.
- Drives the word-indexed read address of the instruction memory and absorbs that memory's one-cycle registered read latency.
- Presents an IF/ID register (valid, pc, instruction) to decode.
- Handles branch redirect, decode stall and out-of-range fetch fault.

Parameters:
- RESET_PC, 64'd0, byte address of the first fetch after reset.
- MEM_WORDS, 1001, number of 32-bit words in the instruction memory. Fetch is legal only when pc[63:2] < MEM_WORDS.

Ports:
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  decode cannot accept; hold the IF/ID register and the in-flight fetch
- branch_taken  in  1  redirect request from the branch stage
- branch_target  in  64  byte address of the redirect
- instruction  in  32  instruction-memory read data. Reflects the address sampled at the previous posedge.
- readAddress  out  64  word index to the instruction memory
- if_id_valid  out  1  IF/ID register holds a real instruction
- if_id_pc  out  64  byte address of if_id_instruction
- if_id_instruction  out  32  fetched instruction
- fault  out  1  sticky: out-of-range pc or misaligned branch target
- fetch_count  out  32  number of instructions loaded into IF/ID since reset

Behaviour:
- Internal state:
  - pc (next byte address to issue)
  - req_valid / req_pc (fetch issued last edge; its data is on `instruction` now)
  - state ∈ {FETCH, HALTED}
- Reset (synchronous, has priority over everything):
  - pc=RESET_PC, req_valid=0, req_pc=0, state=FETCH.
  - if_id_valid=0, if_id_pc=0, if_id_instruction=0, fault=0, fetch_count=0.
- issue = (state==FETCH) && (pc[63:2] < MEM_WORDS).
- readAddress (combinational):
  - req_pc>>2 when stall && req_valid, so the memory re-reads the in-flight word.
  - Otherwise pc>>2.
- Priority per edge (after reset): redirect > stall > normal.
- Redirect (branch_taken=1, state==FETCH):
  - req_valid<=0 and if_id_valid<=0: squash the in-flight and IF/ID instructions.
  - fetch_count unchanged.
  - If branch_target[1:0]!=0: fault<=1, state<=HALTED, pc unchanged.
  - Otherwise pc<=branch_target.
- Redirect while HALTED is ignored.
- Stall (no redirect):
  - pc, req_*, IF/ID, fetch_count and state all hold.
- Normal:
  - if_id_valid<=req_valid. If req_valid: if_id_pc<=req_pc, if_id_instruction<=instruction, fetch_count<=fetch_count+1 (wraps modulo 2^32).
  - If issue: req_valid<=1, req_pc<=pc, pc<=pc+4 (64-bit wrap).
  - Else: req_valid<=0. If state==FETCH: fault<=1 and state<=HALTED.
- HALTED:
  - No new fetches; any in-flight instruction still drains into IF/ID.
  - Fault is sticky; exit only via reset.
- Latency:
  - Address issue to if_id_valid is 2 edges.
  - First if_id_valid after reset release is on the 2nd edge.
  - Steady state delivers 1 instruction per cycle.
- IF/ID fields are don't-care when if_id_valid=0, except after reset, where they are 0.

Test Plan:
- **Straight-line fetch.** Memory preloaded with 8B1F03E5, F84000A4, 8B040086, F80010A6; release reset.
  - readAddress 0,1,2,3 on consecutive cycles.
  - IF/ID shows (pc 0, 8B1F03E5) two edges after release, then pc 4/8/12 with the following words.
  - fetch_count reaches 4 after the 4th load.
- **Stall.** Assert stall for 3 cycles while IF/ID holds pc 4.
  - IF/ID, fetch_count and pc are frozen.
  - readAddress = 2 (in-flight word) during the stall.
  - On release, IF/ID advances to pc 8, 8B040086; no duplicates and no skips.
- **Redirect.** branch_taken=1, branch_target=0x40 while in-flight pc=8.
  - if_id_valid=0 next edge; pc 8 is never delivered.
  - readAddress=16 next cycle; IF/ID valid with pc 0x40 two edges after the redirect.
- **Redirect with simultaneous stall.** Redirect is taken and the stall is ignored for that edge.
- **Misaligned target.** branch_target=0x42.
  - fault=1 next edge; no further if_id_valid; later branch_taken ignored.
  - A reset then clears fault and fetch restarts at RESET_PC.
- **Out-of-range fetch.** RESET_PC=4*(MEM_WORDS-1)=4000.
  - Word 1000 is delivered.
  - On the next edge fault=1 and state HALTED; no further fetches.
  - Mid-operation reset restores all outputs to 0 and pc to 4000.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory port, branch/stall controls from
// later stages and the IF/ID register presented to decode.
interface fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] instruction;
    logic [63:0] readAddress;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, instruction,
        output readAddress, if_id_valid, if_id_pc, if_id_instruction,
        fault, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, instruction,
        input  readAddress, if_id_valid, if_id_pc, if_id_instruction,
        fault, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 program counter and fetch stage: issues word addresses to a memory with
// one-cycle registered read, fills the IF/ID register, handles redirect/stall/fault.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_WORDS = 1001
) (
    input  logic   clock,
    input  logic   reset,
    fetch_if.master fif
);
    localparam logic [63:0] MEM_LIMIT = 64'(MEM_WORDS);

    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc;
    logic        req_vld_p0;
    logic [63:0] req_pc_p0;
    logic        vld_p1;
    logic [63:0] pc_p1;
    logic [31:0] instr_p1;
    logic        fault_q;
    logic [31:0] count_q;

    logic        issue;
    logic        redirect;
    logic        misaligned;
    logic [63:0] read_addr;

    function automatic logic in_range(input logic [63:0] addr);
        return {2'b00, addr[63:2]} < MEM_LIMIT;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Halting happens either on a misaligned redirect or when the next pc has
    // run off the end of memory on an unstalled edge.
    always_comb begin
        state_d = state_q;
        if (state_q == FETCH) begin
            if (fif.branch_taken) begin
                if (misaligned) state_d = HALTED;
            end else if (!fif.stall && !issue) begin
                state_d = HALTED;
            end
        end
    end

    always_comb begin
        issue      = (state_q == FETCH) && in_range(pc);
        redirect   = fif.branch_taken && (state_q == FETCH);
        misaligned = fif.branch_target[1:0] != 2'b00;
        // Under stall the memory must keep presenting the in-flight word.
        read_addr  = (fif.stall && req_vld_p0) ? {2'b00, req_pc_p0[63:2]}
                                               : {2'b00, pc[63:2]};
    end

    // p0: request in flight to memory; p1: IF/ID register
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            req_vld_p0 <= 1'b0;
            req_pc_p0  <= 64'd0;
            vld_p1     <= 1'b0;
            pc_p1      <= 64'd0;
            instr_p1   <= 32'd0;
            fault_q    <= 1'b0;
            count_q    <= 32'd0;
        end else if (redirect) begin
            req_vld_p0 <= 1'b0;
            vld_p1     <= 1'b0;
            if (misaligned) fault_q <= 1'b1;
            else            pc      <= fif.branch_target;
        end else if (!fif.stall) begin
            vld_p1 <= req_vld_p0;
            if (req_vld_p0) begin
                pc_p1    <= req_pc_p0;
                instr_p1 <= fif.instruction;
                count_q  <= count_q + 32'd1;
            end
            if (issue) begin
                req_vld_p0 <= 1'b1;
                req_pc_p0  <= pc;
                pc         <= pc + 64'd4;
            end else begin
                req_vld_p0 <= 1'b0;
                if (state_q == FETCH) fault_q <= 1'b1;
            end
        end
    end

    assign fif.readAddress       = read_addr;
    assign fif.if_id_valid       = vld_p1;
    assign fif.if_id_pc          = pc_p1;
    assign fif.if_id_instruction = instr_p1;
    assign fif.fault             = fault_q;
    assign fif.fetch_count       = count_q;
endmodule
